mac_enc: RTL

- Egress counterpart of the switch's MAC decoder.
- Pops one 114-bit header word from the HEADER-FIFO, serialises its 14 header bytes MSB-first, then streams the matching payload bytes from the BODY-FIFO up to and including the delimiter-flagged byte.
- Writes the rebuilt frame into one of four PHY TX FIFOs.
- Sits between the switching/forwarding stage and the per-port PHY transmit FIFOs.

---
 rtl/mac_enc.sv | 77 +++++++
 1 files changed

// File: rtl/mac_enc.sv
// mac_enc: rebuilds egress frames from header and body FIFOs into one of four PHY TX FIFOs
module mac_enc #(
    parameter int PAYLOAD_MAX = 1500
) (
    input  logic         clk,
    input  logic         arst,
    input  logic [113:0] h_fifo_dout,
    input  logic         h_fifo_empty,
    output logic         h_fifo_rden,
    input  logic [7:0]   b_fifo_dout,
    input  logic         b_fifo_del,
    input  logic         b_fifo_empty,
    output logic         b_fifo_rden,
    output logic [7:0]   o_fifo_din,
    output logic         o_fifo_del,
    output logic [3:0]   o_fifo_wren,
    input  logic [3:0]   o_fifo_afull,
    output logic         frame_done,
    output logic         trunc_err
);
    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_DRAIN, S_END} state_t;
    state_t       state;
    logic [10:0]  cnt;
    logic [111:0] hdr_reg;
    logic [1:0]   port_reg;
    logic         at_max;
    assign h_fifo_rden = state == S_IDLE && !h_fifo_empty && !o_fifo_afull[h_fifo_dout[1:0]];
    assign b_fifo_rden = (state == S_PAYLOAD || state == S_DRAIN) && !b_fifo_empty;
    assign at_max      = cnt + 11'd1 == 11'(PAYLOAD_MAX);
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            hdr_reg     <= '0;
            port_reg    <= '0;
            o_fifo_din  <= '0;
            o_fifo_del  <= 1'b0;
            o_fifo_wren <= '0;
            frame_done  <= 1'b0;
            trunc_err   <= 1'b0;
        end else begin
            o_fifo_wren <= '0;
            o_fifo_del  <= 1'b0;
            frame_done  <= 1'b0;
            trunc_err   <= 1'b0;
            case (state)
                S_IDLE: if (h_fifo_rden) begin
                    hdr_reg  <= h_fifo_dout[113:2];
                    port_reg <= h_fifo_dout[1:0];
                    cnt      <= '0;
                    state    <= S_HEADER;
                end
                S_HEADER: begin
                    o_fifo_din  <= hdr_reg[111:104];
                    hdr_reg     <= hdr_reg << 8;
                    o_fifo_wren <= 4'b0001 << port_reg;
                    cnt         <= cnt == 11'd13 ? 11'd0 : cnt + 11'd1;
                    state       <= cnt == 11'd13 ? S_PAYLOAD : S_HEADER;
                end
                S_PAYLOAD: if (b_fifo_rden) begin
                    o_fifo_din  <= b_fifo_dout;
                    o_fifo_wren <= 4'b0001 << port_reg;
                    o_fifo_del  <= b_fifo_del | at_max;
                    trunc_err   <= !b_fifo_del && at_max;
                    cnt         <= cnt + 11'd1;
                    state       <= b_fifo_del ? S_END : at_max ? S_DRAIN : S_PAYLOAD;
                end
                S_DRAIN: if (b_fifo_rden && b_fifo_del) state <= S_END;
                S_END: begin
                    frame_done <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
